// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pkg
// Description : Shared key codes, FSM state encoding and cycle-count helpers
//               used by the keypad gate.
// Revision    : 1.0
// ============================================================================
package key_pkg;

    localparam logic [3:0] KEY_REARM = 4'hD;
    localparam logic [3:0] KEY_CLR   = 4'hE;
    localparam logic [3:0] KEY_ENT   = 4'hF;

    localparam logic [2:0] c_st_open    = 3'd0;
    localparam logic [2:0] c_st_entry   = 3'd1;
    localparam logic [2:0] c_st_check   = 3'd2;
    localparam logic [2:0] c_st_auth    = 3'd3;
    localparam logic [2:0] c_st_lockout = 3'd4;

    localparam int c_clk_khz = 50_000;

    function automatic int c_ms(input int ms);
        return ms * c_clk_khz;
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lo_timer.sv
`default_nettype none
// ============================================================================
// Module      : lo_timer
// Description : Cycle counter running 0..CMAX-1 while clr is low; done marks
//               the last count.
// Revision    : 1.0
// ============================================================================
module lo_timer #(
    parameter int CMAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic done
);

    localparam int c_cw = (CMAX > 1) ? $clog2(CMAX) : 1;

    logic [c_cw-1:0] r_cnt;

    assign done = (r_cnt == c_cw'(CMAX - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cw'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_gate.sv
`default_nettype none
// ============================================================================
// Module      : key_gate
// Description : Keypad gate: forwards keys while unlocked, otherwise collects a
//               PIN attempt, authenticates it and enforces a timed lockout.
// Revision    : 1.0
// ============================================================================
module key_gate
    import key_pkg::*;
#(
    parameter int PIN_LEN  = 4,
    parameter int MAX_FAIL = 3,
    parameter int LO_CMAX  = c_ms(10000)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lock,
    input  logic                 k_vld,
    input  logic [3:0]           k_code,
    input  logic [4*PIN_LEN-1:0] pin,
    output logic                 o_vld,
    output logic [3:0]           o_code,
    output logic                 auth,
    output logic                 err,
    output logic                 lckout
);

    localparam int c_cnt_w  = $clog2(PIN_LEN + 1);
    localparam int c_fail_w = $clog2(MAX_FAIL + 1);

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [4*PIN_LEN-1:0] r_buf;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_ovf;
    logic [c_fail_w-1:0]  r_fail;
    logic [c_fail_w-1:0]  w_fail_inc;
    logic                 r_o_vld;
    logic [3:0]           r_o_code;
    logic                 r_auth;
    logic                 r_err;
    logic                 r_lckout;
    logic                 w_match;
    logic                 w_fwd;
    logic                 w_lo_clr;
    logic                 w_lo_done;

    assign w_match    = (r_cnt == c_cnt_w'(PIN_LEN)) && !r_ovf && (r_buf == pin);
    assign w_fail_inc = (r_fail == c_fail_w'(MAX_FAIL)) ? r_fail : r_fail + c_fail_w'(1);

    // A key arriving on a lock transition is never forwarded.
    assign w_fwd = k_vld && (((r_state == c_st_open) && !lock) ||
                             ((r_state == c_st_auth) && lock && (k_code != KEY_REARM)));

    assign w_lo_clr = (r_state != c_st_lockout) || !lock;

    lo_timer #(
        .CMAX (LO_CMAX)
    ) u_lo_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_lo_clr),
        .done (w_lo_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (!lock) begin
            w_state_nxt = c_st_open;
        end else begin
            case (r_state)
                c_st_open:    w_state_nxt = c_st_entry;
                c_st_entry:   if (k_vld && (k_code == KEY_ENT)) w_state_nxt = c_st_check;
                c_st_check: begin
                    if (w_match)                               w_state_nxt = c_st_auth;
                    else if (w_fail_inc == c_fail_w'(MAX_FAIL)) w_state_nxt = c_st_lockout;
                    else                                       w_state_nxt = c_st_entry;
                end
                c_st_auth:    if (k_vld && (k_code == KEY_REARM)) w_state_nxt = c_st_entry;
                c_st_lockout: if (w_lo_done) w_state_nxt = c_st_entry;
                default:      w_state_nxt = c_st_open;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_open;
            r_buf    <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_fail   <= '0;
            r_o_vld  <= 1'b0;
            r_o_code <= 4'h0;
            r_auth   <= 1'b0;
            r_err    <= 1'b0;
            r_lckout <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_o_vld  <= w_fwd;
            if (w_fwd) r_o_code <= k_code;
            r_auth   <= (w_state_nxt == c_st_auth);
            r_lckout <= (w_state_nxt == c_st_lockout);
            r_err    <= lock && (r_state == c_st_check) && !w_match;

            if (!lock || (r_state == c_st_open)) begin
                r_buf  <= '0;
                r_cnt  <= '0;
                r_ovf  <= 1'b0;
                r_fail <= '0;
            end else begin
                case (r_state)
                    c_st_entry: begin
                        if (k_vld && is_digit(k_code)) begin
                            r_buf <= (r_buf << 4) | (4*PIN_LEN)'(k_code);
                            if (r_cnt == c_cnt_w'(PIN_LEN)) r_ovf <= 1'b1;
                            else                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end else if (k_vld && (k_code == KEY_CLR)) begin
                            r_buf <= '0;
                            r_cnt <= '0;
                            r_ovf <= 1'b0;
                        end
                    end
                    c_st_check: begin
                        r_buf  <= '0;
                        r_cnt  <= '0;
                        r_ovf  <= 1'b0;
                        r_fail <= w_match ? '0 : w_fail_inc;
                    end
                    c_st_lockout: if (w_lo_done) r_fail <= '0;
                    default: ;
                endcase
            end
        end
    end

    assign o_vld  = r_o_vld;
    assign o_code = r_o_code;
    assign auth   = r_auth;
    assign err    = r_err;
    assign lckout = r_lckout;

endmodule
`default_nettype wire
